// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared types for the ID/EX pipeline register.
//   id_ex_t   - decode-to-execute bundle (widths set by XLEN/RADDR_W/ALUC_W)
//   state_t   - occupancy state of the ID/EX stage {EMPTY, BUSY, FULL}
//   ID_EX_NOP - all-zero bundle (side-effect-free bubble)
package id_ex_pkg;

  parameter int XLEN    = 32;
  parameter int RADDR_W = 5;
  parameter int ALUC_W  = 3;

  typedef struct packed {
    logic               RegWrite;
    logic [1:0]         ResultSrc;
    logic               MemWrite;
    logic               Jump;
    logic               Branch;
    logic [ALUC_W-1:0]  ALUControl;
    logic               ALUSrc;
    logic [XLEN-1:0]    RD1;
    logic [XLEN-1:0]    RD2;
    logic [XLEN-1:0]    PC;
    logic [RADDR_W-1:0] Rs1;
    logic [RADDR_W-1:0] Rs2;
    logic [RADDR_W-1:0] Rd;
    logic [XLEN-1:0]    ImmExt;
    logic [XLEN-1:0]    PCPlus4;
  } id_ex_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam id_ex_t ID_EX_NOP = '0;

endpackage

// File: rtl/id_ex_pipe_skid.sv
// id_ex_skid: one holding entry of the ID/EX stage (data register + valid bit).
//   clk, reset (async, active-high) - clock / reset; reset zeroes data and valid
//   load  - capture d and mark the entry valid
//   clear - invalidate the entry (wins over load)
//   d     - incoming bundle bits
//   q     - held bundle bits
//   vld   - entry holds a live beat
module id_ex_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         vld
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with valid/ready handshake.
//   clk, reset (async, active-high)
//   flush              - kill held and incoming beats at the next edge
//   d_valid/d_ready    - decode-side handshake, d_bundle carries the beat
//   e_valid/e_ready    - execute-side handshake, e_bundle drives execute
//   occ                - number of entries held (0..2)
// Build option: define ID_EX_SKID_EN for the two-entry skid version, where
// d_ready is a register (no e_ready -> d_ready path). Without it a single
// entry is used and d_ready = !e_valid || e_ready.
module id_ex_pipe
  import id_ex_pkg::*;
#(
  parameter int XLEN    = id_ex_pkg::XLEN,
  parameter int RADDR_W = id_ex_pkg::RADDR_W,
  parameter int ALUC_W  = id_ex_pkg::ALUC_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       d_valid,
  output logic       d_ready,
  input  id_ex_t     d_bundle,
  output logic       e_valid,
  input  logic       e_ready,
  output id_ex_t     e_bundle,
  output logic [1:0] occ
);

  localparam int BUNDLE_W = 7 + ALUC_W + 5 * XLEN + 3 * RADDR_W;

  state_t state, state_nxt;
  logic   xfer_in, xfer_out;
  logic   load_main, clr_main;
  id_ex_t main_d, main_q;
  logic   main_vld;

  assign xfer_in  = d_valid && d_ready;
  assign xfer_out = main_vld && e_ready;
  assign e_valid  = main_vld;

`ifdef ID_EX_SKID_EN
  logic   load_skid, clr_skid, main_from_skid;
  id_ex_t skid_q;
  logic   skid_vld;
  logic   d_ready_q;

  assign main_d  = main_from_skid ? skid_q : d_bundle;
  assign d_ready = d_ready_q;
  assign occ     = {1'b0, main_vld} + {1'b0, skid_vld};
`else
  assign main_d  = d_bundle;
  assign d_ready = !main_vld || e_ready;
  assign occ     = {1'b0, main_vld};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef ID_EX_SKID_EN
  // d_ready tracks the next state so it is valid the cycle the state is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_ready_q <= 1'b1;
    end else begin
      d_ready_q <= (state_nxt != FULL);
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    clr_main  = 1'b0;
`ifdef ID_EX_SKID_EN
    load_skid      = 1'b0;
    clr_skid       = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (flush) begin
      clr_main  = 1'b1;
`ifdef ID_EX_SKID_EN
      clr_skid  = 1'b1;
`endif
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (xfer_in) begin
            load_main = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
`ifdef ID_EX_SKID_EN
          if (xfer_in && !xfer_out) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (xfer_in && xfer_out) begin
            load_main = 1'b1;
          end else if (xfer_out) begin
            clr_main  = 1'b1;
            state_nxt = EMPTY;
          end
`else
          if (xfer_in) begin
            load_main = 1'b1;
          end else if (xfer_out) begin
            clr_main  = 1'b1;
            state_nxt = EMPTY;
          end
`endif
        end
`ifdef ID_EX_SKID_EN
        FULL: begin
          // d_ready is low here, so only the drain of main can happen.
          if (xfer_out) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            clr_skid       = 1'b1;
            state_nxt      = BUSY;
          end
        end
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

  id_ex_skid #(.W(BUNDLE_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (load_main),
    .clear (clr_main),
    .d     (main_d),
    .q     (main_q),
    .vld   (main_vld)
  );

`ifdef ID_EX_SKID_EN
  id_ex_skid #(.W(BUNDLE_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (load_skid),
    .clear (clr_skid),
    .d     (d_bundle),
    .q     (skid_q),
    .vld   (skid_vld)
  );
`endif

  // Bubbles must not write registers, memory or redirect the PC.
  always_comb begin
    e_bundle = main_q;
    if (!main_vld) begin
      e_bundle.RegWrite = 1'b0;
      e_bundle.MemWrite = 1'b0;
      e_bundle.Jump     = 1'b0;
      e_bundle.Branch   = 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: self-checking bench for id_ex_pipe (either build of ID_EX_SKID_EN).
module tb_id_ex_pipe;
  import id_ex_pkg::*;

`ifdef ID_EX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       d_valid = 1'b0;
  logic       d_ready;
  id_ex_t     d_bundle = '0;
  logic       e_valid;
  logic       e_ready = 1'b0;
  id_ex_t     e_bundle;
  logic [1:0] occ;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  id_ex_pipe dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_bundle (d_bundle),
    .e_valid  (e_valid),
    .e_ready  (e_ready),
    .e_bundle (e_bundle),
    .occ      (occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  function automatic id_ex_t mk(input logic [31:0] pc);
    id_ex_t b;
    b            = '0;
    b.RegWrite   = 1'b1;
    b.MemWrite   = pc[2];
    b.ResultSrc  = pc[3:2];
    b.ALUControl = pc[4:2];
    b.PC         = pc;
    b.RD1        = ~pc;
    b.RD2        = pc ^ 32'h5a5a5a5a;
    b.ImmExt     = pc << 1;
    b.PCPlus4    = pc + 32'd4;
    b.Rs1        = pc[6:2];
    b.Rs2        = pc[7:3];
    b.Rd         = pc[8:4];
    return b;
  endfunction

  // Apply inputs just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input bit dv, input bit er, input bit fl, input id_ex_t b);
    @(negedge clk);
    d_valid  = dv;
    e_ready  = er;
    flush    = fl;
    d_bundle = b;
    #1;
  endtask

  typedef struct {
    bit          dv;
    bit          er;
    logic [31:0] pc;
    bit          ev;
    logic [31:0] epc;
    logic [1:0]  occ;
    bit          dr;
  } vec_t;

  vec_t vt[10];
  id_ex_t mq[$];

  initial begin
    // Reset state, observed while reset is held.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_e_valid", 192'(e_valid), 192'(0));
    chk("rst_occ", 192'(occ), 192'(0));
    chk("rst_bundle", 192'(e_bundle), 192'(ID_EX_NOP));
    @(negedge clk);
    reset = 1'b0;

`ifdef ID_EX_SKID_EN
    vt[0] = '{0, 1, 32'h000, 0, 32'h000, 2'd0, 1};
    vt[1] = '{1, 1, 32'h100, 0, 32'h000, 2'd0, 1};
    vt[2] = '{0, 1, 32'h100, 1, 32'h100, 2'd1, 1};
    vt[3] = '{1, 1, 32'h104, 0, 32'h000, 2'd0, 1};
    vt[4] = '{1, 0, 32'h108, 1, 32'h104, 2'd1, 1};
    vt[5] = '{1, 0, 32'h10C, 1, 32'h104, 2'd2, 0};
    vt[6] = '{1, 1, 32'h10C, 1, 32'h104, 2'd2, 0};
    vt[7] = '{1, 1, 32'h10C, 1, 32'h108, 2'd1, 1};
    vt[8] = '{0, 1, 32'h000, 1, 32'h10C, 2'd1, 1};
    vt[9] = '{0, 1, 32'h000, 0, 32'h000, 2'd0, 1};
`else
    vt[0] = '{0, 1, 32'h000, 0, 32'h000, 2'd0, 1};
    vt[1] = '{1, 1, 32'h100, 0, 32'h000, 2'd0, 1};
    vt[2] = '{0, 1, 32'h100, 1, 32'h100, 2'd1, 1};
    vt[3] = '{1, 1, 32'h104, 0, 32'h000, 2'd0, 1};
    vt[4] = '{1, 0, 32'h108, 1, 32'h104, 2'd1, 0};
    vt[5] = '{1, 1, 32'h108, 1, 32'h104, 2'd1, 1};
    vt[6] = '{1, 1, 32'h10C, 1, 32'h108, 2'd1, 1};
    vt[7] = '{0, 1, 32'h000, 1, 32'h10C, 2'd1, 1};
    vt[8] = '{0, 1, 32'h000, 0, 32'h000, 2'd0, 1};
    vt[9] = '{0, 1, 32'h000, 0, 32'h000, 2'd0, 1};
`endif

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].dv, vt[i].er, 1'b0, mk(vt[i].pc));
      chk($sformatf("tbl%0d_e_valid", i), 192'(e_valid), 192'(vt[i].ev));
      chk($sformatf("tbl%0d_occ", i), 192'(occ), 192'(vt[i].occ));
      chk($sformatf("tbl%0d_d_ready", i), 192'(d_ready), 192'(vt[i].dr));
      if (vt[i].ev) chk($sformatf("tbl%0d_bundle", i), 192'(e_bundle), 192'(mk(vt[i].epc)));
      else chk($sformatf("tbl%0d_regwrite", i), 192'(e_bundle.RegWrite), 192'(0));
    end

    // Flush while holding CAP entries, with a new beat and a drain in the same cycle.
    drive(1, 0, 0, mk(32'h300));
    drive(1, 0, 0, mk(32'h304));
    drive(1, 1, 1, mk(32'h200));
    chk("fl_pre_occ", 192'(occ), 192'(CAP));
    drive(0, 1, 0, mk(32'h200));
    chk("fl_e_valid", 192'(e_valid), 192'(0));
    chk("fl_occ", 192'(occ), 192'(0));
    drive(0, 1, 0, mk(32'h200));
    chk("fl_no_200", 192'(e_valid), 192'(0));

    // Bubble after draining a beat with all side-effect bits set.
    begin
      id_ex_t b;
      b = mk(32'h400);
      b.RegWrite = 1'b1; b.MemWrite = 1'b1; b.Jump = 1'b1; b.Branch = 1'b1;
      drive(1, 1, 0, b);
      drive(0, 1, 0, b);
      chk("bub_live", 192'(e_bundle), 192'(b));
      drive(0, 1, 0, b);
      chk("bub_e_valid", 192'(e_valid), 192'(0));
      chk("bub_ctrl", 192'({e_bundle.RegWrite, e_bundle.MemWrite, e_bundle.Jump, e_bundle.Branch}), 192'(0));
    end

    // Asynchronous reset between edges while full.
    drive(1, 0, 0, mk(32'h500));
    drive(1, 0, 0, mk(32'h504));
    drive(0, 0, 0, mk(32'h508));
    chk("ar_pre_occ", 192'(occ), 192'(CAP));
    #1 reset = 1'b1;
    #1;
    chk("ar_e_valid", 192'(e_valid), 192'(0));
    chk("ar_occ", 192'(occ), 192'(0));
    chk("ar_d_ready", 192'(d_ready), 192'(1));
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against a FIFO model of bounded capacity.
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      bit dv, er, fl, exp_dr, in_x, out_x;
      logic [191:0] tmp;
      id_ex_t b;
      tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b   = id_ex_t'(tmp[$bits(id_ex_t)-1:0]);
      dv  = ($urandom_range(0, 3) != 0);
      er  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      drive(dv, er, fl, b);
      if (CAP == 2) exp_dr = (mq.size() < 2);
      else exp_dr = (mq.size() == 0) || er;
      chk("rnd_e_valid", 192'(e_valid), 192'(mq.size() > 0));
      chk("rnd_occ", 192'(occ), 192'(mq.size()));
      chk("rnd_d_ready", 192'(d_ready), 192'(exp_dr));
      if (mq.size() > 0) chk("rnd_bundle", 192'(e_bundle), 192'(mq[0]));
      else chk("rnd_bubble", 192'({e_bundle.RegWrite, e_bundle.MemWrite, e_bundle.Jump, e_bundle.Branch}), 192'(0));
      in_x  = dv && exp_dr;
      out_x = (mq.size() > 0) && er;
      if (fl) mq.delete();
      else begin
        if (out_x) void'(mq.pop_front());
        if (in_x) mq.push_back(b);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of RD1/RD2/PC/ImmExt/PCPlus4 fields.
REQ-002 Parameter RADDR_W, default 5, register-address width of Rs1/Rs2/Rd fields.
REQ-003 Parameter ALUC_W, default 3, ALUControl width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  kill all held and incoming beats (taken branch/jump).
REQ-007 d_valid  input  1  decode stage presents a beat.
REQ-008 d_ready  output  1  stage accepts a beat this cycle.
REQ-009 d_bundle  input  id_ex_t  decode bundle: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl, ALUSrc, RD1, RD2, PC, Rs1, Rs2, Rd, ImmExt, PCPlus4.
REQ-010 e_valid  output  1  execute-side beat valid.
REQ-011 e_ready  input  1  execute stage consumes beat (deasserted = stall).
REQ-012 e_bundle  output  id_ex_t  execute-side bundle.
REQ-013 occ  output  2  entries held (0..2).

Function
REQ-014 Transfer in occurs when d_valid && d_ready; transfer out when e_valid && e_ready.
REQ-015 Latency: an accepted beat appears on e_bundle with e_valid=1 the next cycle when the stage was empty.
REQ-016 Storage: main entry (drives e_bundle) and skid entry; states EMPTY (occ=0), BUSY (occ=1), FULL (occ=2).
REQ-017 EMPTY: in -> BUSY; else stay.
REQ-018 BUSY: in without out -> FULL (beat to skid); out without in -> EMPTY; in and out -> BUSY (new beat to main); neither -> stay.
REQ-019 FULL: out -> BUSY with skid moved to main; no input accepted.
REQ-020 d_ready SHALL be a registered signal equal to (state != FULL); no combinational path e_ready -> d_ready.
REQ-021 Beat order SHALL be preserved; no beat duplicated or dropped except by flush.
REQ-022 flush SHALL, at the next edge, clear main and skid valids, discard any beat presented that cycle, and enter EMPTY; flush overrides all simultaneous in/out.
REQ-023 When e_valid=0, e_bundle.RegWrite, MemWrite, Jump and Branch SHALL read 0 (bubble is side-effect free); data fields are don't-care.
REQ-024 Held entries SHALL not change while e_ready=0 except by flush or reset.

Reset
REQ-025 On reset: state EMPTY, occ=0, e_valid=0, d_ready=1 (first cycle after release), all e_bundle fields 0.
REQ-026 Reset asserted mid-operation SHALL discard both entries immediately, asynchronously, independent of clk.

Configuration
REQ-027 Macro ID_EX_SKID_EN defined: two-entry behaviour REQ-016..REQ-020.
REQ-028 ID_EX_SKID_EN undefined: skid entry omitted, states EMPTY/BUSY only, occ max 1, d_ready = !e_valid || e_ready (combinational); all other requirements unchanged.

Structure
REQ-029 Package id_ex_pkg SHALL hold id_ex_t (parametrised via package parameters XLEN/RADDR_W/ALUC_W), the state enum {EMPTY,BUSY,FULL} and constant ID_EX_NOP (all-zero bundle).
REQ-030 One sub-module id_ex_skid (holding register + valid bit with load/clear) is natural; instantiated once per entry.

Verification
REQ-031 Reset then d_valid=1, PC=0x100, e_ready=1 -> next cycle e_valid=1, e_bundle.PC=0x100, occ=1.
REQ-032 e_ready=0, push PC=0x104 then 0x108 -> occ=2, d_ready=0, 0x10C held off; e_ready=1 -> outputs 0x104, 0x108 in order, then 0x10C accepted.
REQ-033 FULL with e_ready=1 and flush=1 same cycle, d_valid=1 PC=0x200 -> next cycle e_valid=0, occ=0, 0x200 never appears.
REQ-034 Bubble: d_valid=0 with RegWrite=1, MemWrite=1 on d_bundle -> e_valid=0, e_bundle.RegWrite=0, MemWrite=0.
REQ-035 Reset asserted between edges while occ=2 -> e_valid=0 and occ=0 before next clk edge.
REQ-036 Build without ID_EX_SKID_EN: e_ready=0, occ=1 -> d_ready=0 same cycle; e_ready=1 with d_valid=1 -> back-to-back throughput 1 beat/cycle.
